tx_serializer: RTL and testbench



---
 rtl/tx_serializer.sv | 164 ++++++++++++++++
 tb/tb_tx_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_serializer.sv
// tx_serializer: pops bytes from a first-word-fall-through tx_fifo and sends
// each one as an async serial frame: start(0), 8 data bits LSB first,
// optional parity, stop(1). The line idles high.
//
// Build option: define TX_SERIALIZER_PARITY_EN to add a parity bit after the
// data bits (sense set by PARITY_ODD: 0 = even, 1 = odd). Without it frames
// are 10 bits and PARITY_ODD has no effect.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high, pop + capture as soon as the FIFO is non-empty
// S_START  | start bit (0) for CLKS_PER_BIT cycles
// S_DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// S_PARITY | parity bit (only with TX_SERIALIZER_PARITY_EN)
// S_STOP   | stop bit (1); frame_done high on its last cycle

`timescale 1ns/1ps

module tx_serializer #(
  parameter int CLKS_PER_BIT = 10,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       fifo_empty,
  input  logic [7:0] read_data,
  output logic       read_enable,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // frame_done is registered, so it is set one cycle ahead of the last
  // stop-bit cycle to line up with it.
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_SERIALIZER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            serial_q;
  logic            frame_done_q;
`ifdef TX_SERIALIZER_PARITY_EN
  logic            parity_q;
`else
  // Parity sense has no effect in this build.
  logic            unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Pop strobe: the pop edge is the same edge that captures read_data.
  // Held low during reset so no byte is popped without being captured.
  assign read_enable = n_rst && (state_q == S_IDLE) && !fifo_empty;
  assign tx_busy     = (state_q != S_IDLE);
  assign serial_out  = serial_q;
  assign frame_done  = frame_done_q;

  // Frame sequencer with registered line and frame_done outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      serial_q     <= 1'b1;
      frame_done_q <= 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            shift_q  <= read_data;
`ifdef TX_SERIALIZER_PARITY_EN
            parity_q <= (^read_data) ^ PARITY_ODD;
`endif
            serial_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            state_q  <= S_START;
          end
        end

        S_START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            serial_q <= shift_q[0];
            state_q  <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q <= 3'd0;
`ifdef TX_SERIALIZER_PARITY_EN
              serial_q <= parity_q;
              state_q  <= S_PARITY;
`else
              serial_q <= 1'b1;
              state_q  <= S_STOP;
`endif
            end else begin
              shift_q  <= {1'b0, shift_q[7:1]};
              bit_q    <= bit_q + 3'd1;
              serial_q <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef TX_SERIALIZER_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            serial_q <= 1'b1;
            state_q  <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_PRE) begin
              frame_done_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          bit_q    <= 3'd0;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Scoreboard bench for tx_serializer: a queue models tx_fifo, every pop pushes
// the expected byte to a scoreboard, and a line monitor checks each frame
// cycle-by-cycle against the popped byte.

`timescale 1ns/1ps

module tb_tx_serializer;

  localparam int CPB   = 10;
  localparam bit P_ODD = 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] read_data = 8'h00;
  logic       read_enable;
  logic       serial_out;
  logic       tx_busy;
  logic       frame_done;

  always #5 clk = ~clk;

  tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(P_ODD)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .fifo_empty (fifo_empty),
    .read_data  (read_data),
    .read_enable(read_enable),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] tb_q[$];
  logic [7:0] sb_q[$];
  int         pop_t[$];
  int         pops = 0;
  int         frames = 0;
  int         aborts = 0;

  logic       in_frame = 1'b0;
  int         off = 0;
  logic [7:0] exp_b = 8'h00;
  logic       has_exp = 1'b0;
  logic       re_neg = 1'b0;

  task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_line(input int o, input logic [7:0] b);
    int bi;
    bi = o / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
`ifdef TX_SERIALIZER_PARITY_EN
    if (bi == 9) return (^b) ^ P_ODD;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pop on the edge that followed a sampled read_enable.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      re_neg = read_enable && n_rst;
      @(posedge clk);
      #1;
      if (re_neg && n_rst) begin
        if (tb_q.size() > 0) begin
          b = tb_q.pop_front();
          sb_q.push_back(b);
          pop_t.push_back(cyc);
          pops++;
        end else begin
          tb_check("pop_when_empty", 1, 0);
        end
      end
      fifo_empty = (tb_q.size() == 0);
      read_data  = (tb_q.size() == 0) ? 8'($urandom) : tb_q[0];
    end
  end

  // Line monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        if (in_frame) begin
          in_frame = 1'b0;
          aborts++;
        end
        tb_check("rst_line", serial_out, 1);
        tb_check("rst_busy", tx_busy, 0);
        tb_check("rst_fd", frame_done, 0);
        tb_check("rst_re", read_enable, 0);
      end else begin
        if (!in_frame) begin
          tb_check("idle_fd", frame_done, 0);
          if (serial_out == 1'b0) begin
            in_frame = 1'b1;
            off      = 0;
            has_exp  = (sb_q.size() > 0);
            if (has_exp) exp_b = sb_q.pop_front();
            else tb_check("unexpected_frame", 1, 0);
          end else begin
            tb_check("idle_busy", tx_busy, 0);
          end
        end
        if (in_frame) begin
          tb_check("busy", tx_busy, 1);
          if (has_exp) tb_check("line", serial_out, exp_line(off, exp_b));
          tb_check("frame_done", frame_done, (off == FL - 1));
          if (off == FL - 1) begin
            in_frame = 1'b0;
            frames++;
          end else begin
            off++;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(tb_q.size() == 0 && !in_frame && !tx_busy && !read_enable) && n < 5000);
    if (n >= 5000) tb_check("timeout_idle", 0, 1);
  endtask

  initial begin
    int base;
    int fbase;
    int n;

    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tb_check("reset_line", serial_out, 1);
    tb_check("reset_busy", tx_busy, 0);
    tb_check("reset_re", read_enable, 0);
    tb_check("reset_fd", frame_done, 0);
    @(posedge clk);
    #3 n_rst = 1'b1;

    // Idle with an empty FIFO: no pops at all.
    repeat (200) begin
      @(negedge clk);
      tb_check("idle_re", read_enable, 0);
    end

    // Single byte.
    tb_q.push_back(8'h0F);
    wait_idle();
    tb_check("single_pops", pops, 1);
    tb_check("single_frames", frames, 1);

    // Two bytes back to back: pops FL+1 apart.
    base = pop_t.size();
    tb_q.push_back(8'h0F);
    tb_q.push_back(8'hF0);
    wait_idle();
    tb_check("two_pops", pop_t.size() - base, 2);
    if (pop_t.size() - base == 2) tb_check("pop_gap", pop_t[base+1] - pop_t[base], FL + 1);

    // Eight bytes, FIFO full.
    fbase = frames;
    for (int i = 0; i < 8; i++) tb_q.push_back(8'($urandom_range(0, 255)));
    wait_idle();
    tb_check("eight_frames", frames - fbase, 8);
    tb_check("eight_line_idle", serial_out, 1);

    // Reset during data bit 3 of 0xA5; 0x3C must follow cleanly.
    fbase = frames;
    tb_q.push_back(8'hA5);
    tb_q.push_back(8'h3C);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(in_frame && off == 46) && n < 500);
    if (n >= 500) tb_check("timeout_bit3", 0, 1);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    tb_check("rst_async_line", serial_out, 1);
    tb_check("rst_async_busy", tx_busy, 0);
    repeat (3) @(posedge clk);
    #3 n_rst = 1'b1;
    wait_idle();
    tb_check("rst_aborts", aborts, 1);
    tb_check("rst_next_frame", frames - fbase, 1);

    // Parity-sensitive bytes and a few more.
    fbase = frames;
    tb_q.push_back(8'h07);
    tb_q.push_back(8'h00);
    tb_q.push_back(8'hFF);
    tb_q.push_back(8'h80);
    wait_idle();
    tb_check("tail_frames", frames - fbase, 4);

    tb_check("sb_drained", sb_q.size(), 0);
    tb_check("fifo_drained", tb_q.size(), 0);
    tb_check("total_pops", pops, frames + aborts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
